// File: rtl/game_pkg.sv
// Shared types and constants for the game controller: state encoding,
// BCD score width and the frame timer width helper.
package game_pkg;

  localparam int BCD_WIDTH = 16;

  // Score value at which the score counter saturates; reaching it ends a game.
  localparam logic [BCD_WIDTH-1:0] SCORE_MAX = 16'h9999;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAYING   = 2'd2,
    OVER      = 2'd3
  } gameState_e;

  // Bits needed to hold (max frame count - 1); never narrower than one bit.
  function automatic int timerWidth(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Signal bundle between the game controller and the rest of the game:
// frame timing, player inputs, score counter control and status outputs.
interface game_ctrl_if;
  import game_pkg::*;

  logic                 frame_tick;
  logic                 btn_start;
  logic                 collision;
  logic [BCD_WIDTH-1:0] score_in;
  logic                 score_clr;
  logic                 game_start;
  logic                 game_over;
  logic                 score_tick;
  logic [1:0]           state;
  logic [BCD_WIDTH-1:0] high_score;
  logic                 new_high;

  // System side: drives frame timing, player inputs and the current score.
  modport master (
    output frame_tick, btn_start, collision, score_in,
    input  score_clr, game_start, game_over, score_tick, state, high_score, new_high
  );

  // Controller side.
  modport slave (
    input  frame_tick, btn_start, collision, score_in,
    output score_clr, game_start, game_over, score_tick, state, high_score, new_high
  );

endinterface

// File: rtl/frame_timer.sv
// Down-counter of frame ticks: loadable, decrements only on a tick and
// saturates at zero so an extra tick can never wrap it around.
module frame_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadValue_i,
  input  logic             tick_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: a load wins, otherwise step down on a tick while non-zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: IDLE -> COUNTDOWN -> PLAYING -> OVER -> IDLE.
// Drives the score counter with one-cycle control pulses, gates the frame
// tick into a score tick while playing and keeps the best score since reset.
module game_ctrl
  import game_pkg::*;
#(
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input logic        clk,
  input logic        rst_n,
  game_ctrl_if.slave bus
);

  localparam int TIMER_W = timerWidth(COUNTDOWN_FRAMES, OVER_HOLD_FRAMES);
  localparam logic [TIMER_W-1:0] COUNTDOWN_LOAD = TIMER_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [TIMER_W-1:0] OVER_LOAD      = TIMER_W'(OVER_HOLD_FRAMES - 1);

  gameState_e state_q, state_d;

  logic btnPrev_q;
  logic scoreClr_q, scoreClr_d;
  logic gameStart_q, gameStart_d;
  logic gameOver_q, gameOver_d;
  logic capture_q;
  logic [BCD_WIDTH-1:0] highScore_q, highScore_d;
  logic newHigh_q, newHigh_d;

  logic startEdge;
  logic playEnd;
  logic timerLoad;
  logic [TIMER_W-1:0] timerLoadValue;
  logic timerTick;
  logic timerZero;

  assign startEdge = bus.btn_start & ~btnPrev_q;
  assign playEnd   = bus.collision | (bus.score_in == SCORE_MAX);
  assign timerTick = bus.frame_tick & ((state_q == COUNTDOWN) | (state_q == OVER));

  frame_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timerLoad),
    .loadValue_i(timerLoadValue),
    .tick_i     (timerTick),
    .zero_o     (timerZero)
  );

  // Next state, timer loads and the registered control pulses for each transition.
  always_comb begin
    state_d        = state_q;
    scoreClr_d     = 1'b0;
    gameStart_d    = 1'b0;
    gameOver_d     = 1'b0;
    timerLoad      = 1'b0;
    timerLoadValue = COUNTDOWN_LOAD;
    case (state_q)
      IDLE: begin
        if (startEdge) begin
          state_d        = COUNTDOWN;
          scoreClr_d     = 1'b1;
          timerLoad      = 1'b1;
          timerLoadValue = COUNTDOWN_LOAD;
        end
      end
      COUNTDOWN: begin
        if (bus.frame_tick && timerZero) begin
          state_d     = PLAYING;
          gameStart_d = 1'b1;
        end
      end
      PLAYING: begin
        if (playEnd) begin
          state_d        = OVER;
          gameOver_d     = 1'b1;
          timerLoad      = 1'b1;
          timerLoadValue = OVER_LOAD;
        end
      end
      OVER: begin
        if (bus.frame_tick && timerZero) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // High score bookkeeping: new game clears the flag, the delayed capture may set it.
  always_comb begin
    highScore_d = highScore_q;
    newHigh_d   = newHigh_q;
    if ((state_q == IDLE) && startEdge) begin
      newHigh_d = 1'b0;
    end
    if (capture_q && (bus.score_in > highScore_q)) begin
      highScore_d = bus.score_in;
      newHigh_d   = 1'b1;
    end
  end

  // State, edge detector, pulse and score registers; capture runs one cycle behind game_over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      btnPrev_q   <= 1'b0;
      scoreClr_q  <= 1'b0;
      gameStart_q <= 1'b0;
      gameOver_q  <= 1'b0;
      capture_q   <= 1'b0;
      highScore_q <= '0;
      newHigh_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      btnPrev_q   <= bus.btn_start;
      scoreClr_q  <= scoreClr_d;
      gameStart_q <= gameStart_d;
      gameOver_q  <= gameOver_d;
      capture_q   <= gameOver_q;
      highScore_q <= highScore_d;
      newHigh_q   <= newHigh_d;
    end
  end

  assign bus.score_clr  = scoreClr_q;
  assign bus.game_start = gameStart_q;
  assign bus.game_over  = gameOver_q;
  assign bus.score_tick = bus.frame_tick & (state_q == PLAYING);
  assign bus.state      = state_q;
  assign bus.high_score = highScore_q;
  assign bus.new_high   = newHigh_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed sequences and a vector table
// for the corner cases, then random play checked against a game-rules model.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int CD = 180;
  localparam int OH = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  game_ctrl_if gif();

  game_ctrl #(
    .COUNTDOWN_FRAMES(CD),
    .OVER_HOLD_FRAMES(OH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (gif.slave)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int nVec = 0;
  int nMiss = 0;

  // Game-rules model: phase number, cycles spent in the phase, frame ticks
  // counted in the phase, last button level and the best score so far.
  int          mPhase;
  int          mCyc;
  int          mTicks;
  logic        mPrev;
  logic [15:0] mHigh;
  logic        mNewHigh;

  logic        curFt, curBtn, curColl;
  logic [15:0] curScore;

  typedef struct {
    logic        ft;
    logic        coll;
    logic [15:0] score;
    logic [1:0]  expState;
    logic        expTick;
    logic        expOver;
    logic [15:0] expHigh;
    logic        expNew;
  } vec_t;

  vec_t tbl[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mPhase   = 0;
    mCyc     = 0;
    mTicks   = 0;
    mPrev    = 1'b0;
    mHigh    = 16'h0000;
    mNewHigh = 1'b0;
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic modelStep();
    int  nextPhase;
    logic rise;
    nextPhase = mPhase;
    rise = curBtn && !mPrev;
    if (mPhase == 3 && mCyc == 1 && curScore > mHigh) begin
      mHigh    = curScore;
      mNewHigh = 1'b1;
    end
    case (mPhase)
      0: if (rise) begin nextPhase = 1; mNewHigh = 1'b0; mTicks = 0; end
      1: if (curFt) begin mTicks++; if (mTicks == CD) nextPhase = 2; end
      2: if (curColl || curScore == 16'h9999) begin nextPhase = 3; mTicks = 0; end
      default: if (curFt) begin mTicks++; if (mTicks == OH) nextPhase = 0; end
    endcase
    mCyc   = (nextPhase != mPhase) ? 0 : mCyc + 1;
    mPhase = nextPhase;
    mPrev  = curBtn;
  endtask

  function automatic logic [22:0] modelExpected();
    logic [1:0] st;
    st = 2'(mPhase);
    return {st, (mPhase == 1 && mCyc == 0), (mPhase == 2 && mCyc == 0),
            (mPhase == 3 && mCyc == 0), (curFt && mPhase == 2), mHigh, mNewHigh};
  endfunction

  function automatic logic [22:0] dutOuts();
    return {gif.state, gif.score_clr, gif.game_start, gif.game_over, gif.score_tick,
            gif.high_score, gif.new_high};
  endfunction

  // One clock: close the previous cycle in the model, drive new inputs at
  // the falling edge and compare all outputs against the model.
  task automatic applyStimulus(input logic ft, input logic btn, input logic coll, input logic [15:0] score);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    gif.frame_tick = ft;
    gif.btn_start  = btn;
    gif.collision  = coll;
    gif.score_in   = score;
    curFt = ft; curBtn = btn; curColl = coll; curScore = score;
    #1;
    checkOutput("model", 32'(dutOuts()), 32'(modelExpected()));
  endtask

  // Asynchronous reset in the low clock phase with busy inputs, then release.
  task automatic resetDut();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    gif.frame_tick = 1'b1;
    gif.btn_start  = 1'b1;
    gif.collision  = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_state", 32'(gif.state), 32'(2'd0));
    checkOutput("rst_high", 32'(gif.high_score), 32'(16'h0000));
    checkOutput("rst_newhigh", 32'(gif.new_high), 32'(1'b0));
    checkOutput("rst_pulses", 32'({gif.score_clr, gif.game_start, gif.game_over, gif.score_tick}), 32'(4'b0000));
    @(negedge clk);
    gif.frame_tick = 1'b0; gif.btn_start = 1'b0; gif.collision = 1'b0; gif.score_in = 16'h0000;
    curFt = 1'b0; curBtn = 1'b0; curColl = 1'b0; curScore = 16'h0000;
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic pressStart();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic runUntilState(input int target, input logic ft, input logic btn, input int budget, input string name);
    for (int i = 0; i < budget && int'(gif.state) != target; i++) begin
      applyStimulus(ft, btn, 1'b0, 16'h0000);
    end
    checkOutput(name, 32'(gif.state), 32'(target));
  endtask

  // Full game ending on finalScore, leaving the bench one cycle after the capture.
  task automatic playGame(input logic [15:0] finalScore, input logic useColl);
    pressStart();
    runUntilState(2, 1'b1, 1'b0, 400, "reach_playing");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0001);
    applyStimulus(1'b0, 1'b0, useColl, finalScore);
    applyStimulus(1'b0, 1'b0, 1'b0, finalScore);
    checkOutput("over_pulse", 32'({gif.state, gif.game_over}), 32'({2'd3, 1'b1}));
    applyStimulus(1'b0, 1'b0, 1'b0, finalScore);
    applyStimulus(1'b0, 1'b0, 1'b0, finalScore);
  endtask

  function automatic logic [15:0] randBcd();
    logic [3:0] d0, d1, d2, d3;
    d0 = 4'($urandom_range(0, 9));
    d1 = 4'($urandom_range(0, 9));
    d2 = 4'($urandom_range(0, 9));
    d3 = 4'($urandom_range(0, 9));
    return {d3, d2, d1, d0};
  endfunction

  // Hard stop in case the bench itself stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    logic randBtn;

    tbl[0]  = '{1'b1, 1'b0, 16'h0042, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0042, 2'd2, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0042, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0042, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0042, 2'd2, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0042, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0042, 2'd2, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 16'h0042, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'h0042, 2'd3, 1'b0, 1'b1, 16'h0000, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'h0042, 2'd3, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h0042, 2'd3, 1'b0, 1'b0, 16'h0042, 1'b1};

    gif.frame_tick = 1'b0; gif.btn_start = 1'b0; gif.collision = 1'b0; gif.score_in = 16'h0000;
    curFt = 1'b0; curBtn = 1'b0; curColl = 1'b0; curScore = 16'h0000;
    modelReset();
    resetDut();

    // Start edge, score clear, then the full countdown into PLAYING.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("edge_idle", 32'({gif.state, gif.score_clr}), 32'({2'd0, 1'b0}));
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("clr_pulse", 32'({gif.state, gif.score_clr}), 32'({2'd1, 1'b1}));
    for (int i = 0; i < CD; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("countdown", 32'({gif.state, gif.score_tick, gif.score_clr}), 32'({2'd1, 1'b0, 1'b0}));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("game_start", 32'({gif.state, gif.game_start}), 32'({2'd2, 1'b1}));

    // Score ticks while playing, collision with a tick, capture of 0042.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].ft, 1'b0, tbl[i].coll, tbl[i].score);
      checkOutput($sformatf("tbl%0d", i),
                  32'({gif.state, gif.score_tick, gif.game_over, gif.high_score, gif.new_high}),
                  32'({tbl[i].expState, tbl[i].expTick, tbl[i].expOver, tbl[i].expHigh, tbl[i].expNew}));
    end
    runUntilState(0, 1'b1, 1'b0, 400, "over_to_idle");

    // A lower score leaves the record alone.
    playGame(16'h0017, 1'b1);
    checkOutput("g2_high", 32'(gif.high_score), 32'(16'h0042));
    checkOutput("g2_newhigh", 32'(gif.new_high), 32'(1'b0));
    runUntilState(0, 1'b1, 1'b0, 400, "g2_idle");

    // Reset in the middle of a game wipes the record.
    pressStart();
    runUntilState(2, 1'b1, 1'b0, 400, "g3_playing");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0005);
    checkOutput("pre_rst_high", 32'(gif.high_score), 32'(16'h0042));
    resetDut();

    // Saturated score ends the game without a collision.
    playGame(16'h9999, 1'b0);
    checkOutput("max_high", 32'(gif.high_score), 32'(16'h9999));
    checkOutput("max_newhigh", 32'(gif.new_high), 32'(1'b1));

    // Button held through OVER -> IDLE must not start a new game.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    runUntilState(0, 1'b1, 1'b1, 400, "held_idle");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      checkOutput("held_no_retrigger", 32'({gif.state, gif.score_clr}), 32'({2'd0, 1'b0}));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("repress_start", 32'({gif.state, gif.score_clr}), 32'({2'd1, 1'b1}));

    // Random play against the model, with one reset along the way.
    randBtn = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      logic [15:0] sc;
      if (c == 2000) resetDut();
      if ($urandom_range(0, 7) == 0) randBtn = ~randBtn;
      sc = ($urandom_range(0, 99) == 0) ? 16'h9999 : randBcd();
      applyStimulus($urandom_range(0, 3) != 0, randBtn, $urandom_range(0, 49) == 0, sc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
